// File: rtl/ascii_conv_arbiter.sv
// Round-robin arbiter in front of one shared 12-bit binary to 4-digit ASCII converter.
// Each granted value is converted by successive subtraction of 1000/100/10/1, and the
// result is returned tagged with the index of the requester that was granted.
module ascii_conv_arbiter #(
    parameter int unsigned N_REQ = 4,
    parameter int unsigned IDX_W = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [N_REQ-1:0]     req,
    input  logic [N_REQ*12-1:0]  val,
    output logic [N_REQ-1:0]     gnt,
    output logic                 busy,
    output logic                 done_valid,
    output logic [IDX_W-1:0]     done_id,
    output logic [31:0]          done_ascii
);

    localparam int unsigned VAL_W = 12;
    localparam int unsigned CNT_W = 4;
    localparam int unsigned DIG_W = 2;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CONV = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             r_state;
    logic [IDX_W-1:0]   r_ptr;
    logic [IDX_W-1:0]   r_id;
    logic [VAL_W-1:0]   r_rem;
    logic [CNT_W-1:0]   r_cnt;
    logic [DIG_W-1:0]   r_digit;
    logic [31:0]        r_work;

    logic               w_any;
    logic [IDX_W-1:0]   w_sel;
    logic [N_REQ-1:0]   w_gnt;
    logic [VAL_W-1:0]   w_sel_val;
    logic [VAL_W-1:0]   w_weight;
    logic [7:0]         w_byte;
    int                 w_best;
    int                 w_dist;

    // Round-robin pick: the set request closest after r_ptr (distance 0 = r_ptr+1) wins.
    always_comb begin
        w_any  = 1'b0;
        w_sel  = '0;
        w_best = int'(N_REQ);
        w_dist = 0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (req[i]) begin
                w_dist = (i + int'(N_REQ) - 1 - int'(r_ptr)) % int'(N_REQ);
                if (w_dist < w_best) begin
                    w_best = w_dist;
                    w_sel  = IDX_W'(i);
                    w_any  = 1'b1;
                end
            end
        end
    end

    // One-hot grant vector and value mux for the selected requester.
    always_comb begin
        w_gnt     = '0;
        w_sel_val = '0;
        for (int i = 0; i < int'(N_REQ); i++) begin
            if (IDX_W'(i) == w_sel) begin
                w_gnt[i]  = 1'b1;
                w_sel_val = val[VAL_W*i +: VAL_W];
            end
        end
    end

    // Decimal weight of the digit currently being extracted, and its ASCII byte.
    always_comb begin
        case (r_digit)
            2'd3:    w_weight = 12'd1000;
            2'd2:    w_weight = 12'd100;
            2'd1:    w_weight = 12'd10;
            default: w_weight = 12'd1;
        endcase
        w_byte = 8'h30 + {4'h0, r_cnt};
    end

    // Arbitration / conversion FSM with registered outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_ptr      <= IDX_W'(N_REQ - 1);
            r_id       <= '0;
            r_rem      <= '0;
            r_cnt      <= '0;
            r_digit    <= '0;
            r_work     <= '0;
            gnt        <= '0;
            busy       <= 1'b0;
            done_valid <= 1'b0;
            done_id    <= '0;
            done_ascii <= '0;
        end else begin
            gnt        <= '0;
            done_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        gnt     <= w_gnt;
                        r_rem   <= w_sel_val;
                        r_id    <= w_sel;
                        r_ptr   <= w_sel;
                        r_digit <= 2'd3;
                        r_cnt   <= '0;
                        busy    <= 1'b1;
                        r_state <= S_CONV;
                    end
                end
                S_CONV: begin
                    if (r_rem >= w_weight) begin
                        r_rem <= r_rem - w_weight;
                        r_cnt <= r_cnt + 4'd1;
                    end else begin
                        case (r_digit)
                            2'd3:    r_work[31:24] <= w_byte;
                            2'd2:    r_work[23:16] <= w_byte;
                            2'd1:    r_work[15:8]  <= w_byte;
                            default: r_work[7:0]   <= w_byte;
                        endcase
                        r_cnt <= '0;
                        if (r_digit == 2'd0) begin
                            r_state <= S_DONE;
                        end else begin
                            r_digit <= r_digit - 2'd1;
                        end
                    end
                end
                S_DONE: begin
                    done_valid <= 1'b1;
                    done_ascii <= r_work;
                    done_id    <= r_id;
                    busy       <= 1'b0;
                    r_state    <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ascii_conv_arbiter.sv
// Scoreboard bench for ascii_conv_arbiter: stimulus pushes expected results,
// an independent monitor pops and compares on every done_valid pulse.
module tb_ascii_conv_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [11:0] v [4];
    logic [47:0] val;
    logic [3:0]  gnt;
    logic        busy;
    logic        done_valid;
    logic [1:0]  done_id;
    logic [31:0] done_ascii;

    typedef struct {
        logic [1:0]  id;
        logic [31:0] ascii;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   checks;
    int   failures;
    int   g_wait;

    assign val = {v[3], v[2], v[1], v[0]};

    ascii_conv_arbiter #(.N_REQ(4), .IDX_W(2)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req        (req),
        .val        (val),
        .gnt        (gnt),
        .busy       (busy),
        .done_valid (done_valid),
        .done_id    (done_id),
        .done_ascii (done_ascii)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every result pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (done_valid) begin
            if (q.size() == 0) begin
                chk("done_with_empty_queue", 64'(q.size()), 64'd1);
            end else begin
                mon_e = q.pop_front();
                chk("done_id", 64'(done_id), 64'(mon_e.id));
                chk("done_ascii", 64'(done_ascii), 64'(mon_e.ascii));
            end
        end
    end

    task automatic expect_result(input int idx, input logic [31:0] ascii);
        exp_t e;
        e.id    = 2'(idx);
        e.ascii = ascii;
        q.push_back(e);
    endtask

    // Wait (bounded) for the next grant pulse and compare it.
    task automatic wait_gnt(input logic [3:0] exp_g, input string name);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (gnt == 4'b0000 && n < 100);
        g_wait = n;
        chk(name, 64'(gnt), 64'(exp_g));
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((q.size() != 0 || busy) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'(q.size()), 64'd0);
        repeat (2) @(negedge clk);
    endtask

    task automatic do_reset();
        @(posedge clk); #1;
        rst_n = 1'b0;
        req   = 4'b0000;
        repeat (3) @(negedge clk);
        @(posedge clk); #1;
        rst_n = 1'b1;
    endtask

    // Single request on one requester; optionally checks grant-to-result latency.
    task automatic run_one(input int idx, input logic [11:0] value,
                           input logic [31:0] ascii, input int exp_lat);
        int lat;
        @(posedge clk); #1;
        v[idx] = value;
        req    = 4'(1 << idx);
        expect_result(idx, ascii);
        wait_gnt(4'(1 << idx), "gnt_single");
        req = 4'b0000;
        if (exp_lat > 0) begin
            lat = 0;
            do begin
                @(negedge clk);
                lat++;
            end while (!done_valid && lat < 100);
            chk("latency", 64'(lat), 64'(exp_lat));
        end
        drain();
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        for (int i = 0; i < 4; i++) v[i] = 12'd0;
        repeat (3) @(negedge clk);
        chk("rst_gnt", 64'(gnt), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done_valid", 64'(done_valid), 64'd0);
        chk("rst_done_ascii", 64'(done_ascii), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // 1: single conversion, grant visible right after the first rising edge
        @(posedge clk); #1;
        v[0] = 12'd1234;
        req  = 4'b0001;
        expect_result(0, 32'h31323334);
        wait_gnt(4'b0001, "t1_gnt");
        chk("t1_gnt_delay", 64'(g_wait), 64'd2);
        chk("t1_busy", 64'(busy), 64'd1);
        req = 4'b0000;
        drain();

        // 2: boundaries 0, 4095 and worst-case 3999
        run_one(0, 12'd0,    32'h30303030, 5);
        run_one(0, 12'd4095, 32'h34303935, 0);
        run_one(0, 12'd3999, 32'h33393939, 35);

        // 3: all requesting from fresh reset -> order 0,1,2,3,0
        do_reset();
        v[0] = 12'd42;
        v[1] = 12'd999;
        v[2] = 12'd2500;
        v[3] = 12'd7;
        expect_result(0, 32'h30303432);
        expect_result(1, 32'h30393939);
        expect_result(2, 32'h32353030);
        expect_result(3, 32'h30303037);
        expect_result(0, 32'h30303432);
        @(posedge clk); #1;
        req = 4'b1111;
        for (int k = 0; k < 5; k++) wait_gnt(4'(1 << (k % 4)), "t3_rr_order");
        req = 4'b0000;
        drain();

        // 4: pointer at 1, requests on 1 and 3 -> 3 then wrap to 1
        run_one(1, 12'd5, 32'h30303035, 0);
        v[1] = 12'd100;
        v[3] = 12'd3210;
        expect_result(3, 32'h33323130);
        expect_result(1, 32'h30313030);
        @(posedge clk); #1;
        req = 4'b1010;
        wait_gnt(4'b1000, "t4_first");
        wait_gnt(4'b0010, "t4_wrap");
        req = 4'b0000;
        drain();

        // 5: value changed after grant does not affect result
        @(posedge clk); #1;
        v[1] = 12'd321;
        req  = 4'b0010;
        expect_result(1, 32'h30333231);
        wait_gnt(4'b0010, "t5_gnt");
        req = 4'b0000;
        @(posedge clk); #1;
        v[1] = 12'd4000;
        drain();

        // 6: reset mid-conversion aborts with no result
        @(posedge clk); #1;
        v[0] = 12'd3999;
        req  = 4'b0001;
        wait_gnt(4'b0001, "t6_gnt");
        req = 4'b0000;
        repeat (5) @(posedge clk);
        #1;
        rst_n = 1'b0;
        v[0] = 12'd11;
        v[1] = 12'd22;
        v[2] = 12'd33;
        v[3] = 12'd44;
        req  = 4'b1111;
        @(negedge clk);
        chk("t6_rst_gnt", 64'(gnt), 64'd0);
        chk("t6_rst_busy", 64'(busy), 64'd0);
        chk("t6_rst_done_id", 64'(done_id), 64'd0);
        chk("t6_rst_done_ascii", 64'(done_ascii), 64'd0);
        repeat (3) begin
            @(negedge clk);
            chk("t6_rst_done_valid", 64'(done_valid), 64'd0);
        end
        @(posedge clk); #1;
        rst_n = 1'b1;
        expect_result(0, 32'h30303131);
        wait_gnt(4'b0001, "t6_gnt_after_reset");
        req = 4'b0000;
        drain();
        repeat (40) @(negedge clk);
        chk("final_queue_empty", 64'(q.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

endmodule
